// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: bus widths, field
// offsets of the EXE->MEM and MEM->WB buses, and the access FSM encoding.
package mem_access_pkg;

   localparam int EXE_MEM_BUS_W = 155;
   localparam int MEM_WB_BUS_W  = 120;

   // mem_control = {inst_load, inst_store, ls_word, lb_sign}
   localparam int MC_LOAD  = 3;
   localparam int MC_STORE = 2;
   localparam int MC_WORD  = 1;
   localparam int MC_SIGN  = 0;

   // EXE->MEM bus field offsets (LSB position of each field)
   localparam int EM_PC         = 0;    // 32 bits
   localparam int EM_OVERFLOW   = 32;   // 1 bit
   localparam int EM_WDEST      = 33;   // 5 bits
   localparam int EM_RF_WEN     = 38;   // 1 bit
   localparam int EM_SYS        = 39;   // {syscall, eret}
   localparam int EM_CP0R       = 41;   // 8 bits
   localparam int EM_FLAGS      = 49;   // {hi_write, lo_write, mfhi, mflo, mtc0, mfc0}
   localparam int EM_LO_RESULT  = 55;   // 32 bits
   localparam int EM_EXE_RESULT = 87;   // 32 bits
   localparam int EM_STORE_DATA = 119;  // 32 bits
   localparam int EM_MEM_CTRL   = 151;  // 4 bits

   // MEM->WB bus field offsets, also used by the writeback stage
   localparam int MW_PC         = 0;    // 32 bits
   localparam int MW_ADDR_ERR   = 32;   // 1 bit
   localparam int MW_OVERFLOW   = 33;   // 1 bit
   localparam int MW_SYS        = 34;   // {syscall, eret}
   localparam int MW_CP0R       = 36;   // 8 bits
   localparam int MW_FLAGS      = 44;   // {hi_write, lo_write, mfhi, mflo, mtc0, mfc0}
   localparam int MW_LO_RESULT  = 50;   // 32 bits
   localparam int MW_MEM_RESULT = 82;   // 32 bits
   localparam int MW_WDEST      = 114;  // 5 bits
   localparam int MW_RF_WEN     = 119;  // 1 bit

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RDATA = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Byte-lane write enables for a store: full word, or one lane picked by the low address bits.
   function automatic logic [3:0] store_wen(input logic ls_word, input logic [1:0] offset);
      return ls_word ? 4'hF : (4'b0001 << offset);
   endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Picks one byte of a loaded word by address offset (little-endian lanes)
// and sign- or zero-extends it to 32 bits.
module mem_access_load_align
   import mem_access_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic        sign,
   output logic [31:0] result
);

   logic [7:0] sel_byte;

   // Select the addressed byte lane and extend it.
   always_comb begin
      sel_byte = word[7:0];
      case (offset)
         2'd0: sel_byte = word[7:0];
         2'd1: sel_byte = word[15:8];
         2'd2: sel_byte = word[23:16];
         2'd3: sel_byte = word[31:24];
         default: sel_byte = word[7:0];
      endcase
      result = {{24{sign & sel_byte[7]}}, sel_byte};
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores to the data RAM over a
// request/ready handshake, aligns load data and builds the MEM->WB bus.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int EXE_MEM_W = EXE_MEM_BUS_W,
   parameter int MEM_WB_W  = MEM_WB_BUS_W
)(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 MEM_valid,
   input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
   input  logic                 MEM_WB_go,
   input  logic                 dm_ready,
   input  logic [31:0]          dm_rdata,
   output logic                 dm_en,
   output logic [3:0]           dm_wen,
   output logic [31:0]          dm_addr,
   output logic [31:0]          dm_wdata,
   output logic                 MEM_over,
   output logic [MEM_WB_W-1:0]  MEM_WB_bus,
   output logic [4:0]           MEM_wdest,
   output logic [31:0]          MEM_pc
);

   logic [3:0]  mem_control;
   logic        inst_load, inst_store, ls_word, lb_sign;
   logic [31:0] store_data, exe_result, lo_result, pc;
   logic [5:0]  flags;
   logic [7:0]  cp0r_addr;
   logic [1:0]  sys;
   logic        rf_wen, overflow;
   logic [4:0]  rf_wdest;

   assign mem_control = EXE_MEM_bus_r[EM_MEM_CTRL   +: 4];
   assign store_data  = EXE_MEM_bus_r[EM_STORE_DATA +: 32];
   assign exe_result  = EXE_MEM_bus_r[EM_EXE_RESULT +: 32];
   assign lo_result   = EXE_MEM_bus_r[EM_LO_RESULT  +: 32];
   assign flags       = EXE_MEM_bus_r[EM_FLAGS      +: 6];
   assign cp0r_addr   = EXE_MEM_bus_r[EM_CP0R       +: 8];
   assign sys         = EXE_MEM_bus_r[EM_SYS        +: 2];
   assign rf_wen      = EXE_MEM_bus_r[EM_RF_WEN];
   assign rf_wdest    = EXE_MEM_bus_r[EM_WDEST      +: 5];
   assign overflow    = EXE_MEM_bus_r[EM_OVERFLOW];
   assign pc          = EXE_MEM_bus_r[EM_PC         +: 32];

   assign inst_load  = mem_control[MC_LOAD];
   assign inst_store = mem_control[MC_STORE];
   assign ls_word    = mem_control[MC_WORD];
   assign lb_sign    = mem_control[MC_SIGN];

   logic mem_op, mis, addr_err;
   assign mem_op   = inst_load | inst_store;
   assign mis      = ls_word & (exe_result[1:0] != 2'b00);
   assign addr_err = mis & mem_op;

   state_t      state, next_state;
   logic [31:0] load_data;
   logic        req, over;

   // State register; reset abandons any access in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= next_state;
   end

   // Capture read data the cycle after the load was accepted.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)             load_data <= '0;
      else if (state == RDATA) load_data <= dm_rdata;
   end

   // Next-state and handshake/completion decode.
   always_comb begin
      next_state = state;
      req        = 1'b0;
      over       = 1'b0;
      case (state)
         IDLE: begin
            req  = MEM_valid & mem_op & ~mis;
            // Non-memory and misaligned instructions finish without touching the RAM.
            over = MEM_valid & ~(mem_op & ~mis);
            if (req & dm_ready) next_state = inst_load ? RDATA : DONE;
         end
         RDATA: next_state = DONE;
         DONE: begin
            // A flushed instruction passes through DONE silently.
            over = MEM_valid;
            if (MEM_WB_go | ~MEM_valid) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is asserted.
   assign dm_en    = req & resetn;
   assign MEM_over = over & resetn;
   assign dm_wen   = (dm_en & inst_store) ? store_wen(ls_word, exe_result[1:0]) : 4'h0;
   assign dm_addr  = exe_result;
   assign dm_wdata = ls_word ? store_data : {4{store_data[7:0]}};

   logic [31:0] byte_result, mem_result;

   mem_access_load_align u_load_align (
      .word   (load_data),
      .offset (exe_result[1:0]),
      .sign   (lb_sign),
      .result (byte_result)
   );

   assign mem_result = !inst_load ? exe_result :
                       ls_word    ? load_data  : byte_result;

   // Pack the MEM->WB bus at the shared field offsets.
   always_comb begin
      MEM_WB_bus                         = '0;
      MEM_WB_bus[MW_RF_WEN]              = rf_wen;
      MEM_WB_bus[MW_WDEST      +: 5]     = rf_wdest;
      MEM_WB_bus[MW_MEM_RESULT +: 32]    = mem_result;
      MEM_WB_bus[MW_LO_RESULT  +: 32]    = lo_result;
      MEM_WB_bus[MW_FLAGS      +: 6]     = flags;
      MEM_WB_bus[MW_CP0R       +: 8]     = cp0r_addr;
      MEM_WB_bus[MW_SYS        +: 2]     = sys;
      MEM_WB_bus[MW_OVERFLOW]            = overflow;
      MEM_WB_bus[MW_ADDR_ERR]            = addr_err;
      MEM_WB_bus[MW_PC         +: 32]    = pc;
   end

   assign MEM_wdest = rf_wdest & {5{MEM_valid}};
   assign MEM_pc    = pc;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for the memory-access stage with a small RAM responder.
module tb_mem_access;

   logic         clk = 1'b0;
   logic         resetn;
   logic         MEM_valid;
   logic [154:0] EXE_MEM_bus_r;
   logic         MEM_WB_go;
   logic         dm_ready;
   logic [31:0]  dm_rdata = 32'hCCCC_CCCC;
   logic         dm_en;
   logic [3:0]   dm_wen;
   logic [31:0]  dm_addr, dm_wdata;
   logic         MEM_over;
   logic [119:0] MEM_WB_bus;
   logic [4:0]   MEM_wdest;
   logic [31:0]  MEM_pc;

   logic         wb_allow;
   logic [31:0]  rd_word;
   int           wr_cnt = 0;
   int           total = 0;
   int           bad = 0;

   always #5 clk = ~clk;

   assign MEM_WB_go = MEM_over & wb_allow;

   mem_access dut (
      .clk           (clk),
      .resetn        (resetn),
      .MEM_valid     (MEM_valid),
      .EXE_MEM_bus_r (EXE_MEM_bus_r),
      .MEM_WB_go     (MEM_WB_go),
      .dm_ready      (dm_ready),
      .dm_rdata      (dm_rdata),
      .dm_en         (dm_en),
      .dm_wen        (dm_wen),
      .dm_addr       (dm_addr),
      .dm_wdata      (dm_wdata),
      .MEM_over      (MEM_over),
      .MEM_WB_bus    (MEM_WB_bus),
      .MEM_wdest     (MEM_wdest),
      .MEM_pc        (MEM_pc)
   );

   // RAM responder: read data only in the cycle after an accepted load.
   always @(posedge clk) begin
      dm_rdata <= (dm_en && dm_ready && dm_wen == 4'h0) ? rd_word : 32'hCCCC_CCCC;
      if (dm_en && dm_ready && dm_wen != 4'h0) wr_cnt <= wr_cnt + 1;
   end

   // Output bus unpacked in the documented field order.
   logic        o_rf_wen, o_ovf, o_aerr;
   logic [4:0]  o_wdest;
   logic [31:0] o_res, o_lo, o_pc;
   logic [5:0]  o_flags;
   logic [7:0]  o_cp0r;
   logic [1:0]  o_sys;
   assign {o_rf_wen, o_wdest, o_res, o_lo, o_flags, o_cp0r, o_sys, o_ovf, o_aerr, o_pc} = MEM_WB_bus;

   function automatic logic [154:0] mk(input logic [3:0] ctrl, input logic [31:0] sd,
                                       input logic [31:0] exe, input logic [4:0] wd,
                                       input logic [31:0] pc);
      return {ctrl, sd, exe, 32'h0000_1111, 6'b101010, 8'hA5, 2'b10, 1'b1, wd, 1'b1, pc};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [3:0] C_ALU = 4'b0000, C_LW = 4'b1010, C_LB = 4'b1001,
                          C_LBU = 4'b1000, C_SB = 4'b0100, C_SW = 4'b0110;

   int            wc;
   logic [119:0]  snap;

   initial begin
      resetn = 1'b0; MEM_valid = 1'b0; EXE_MEM_bus_r = '0;
      wb_allow = 1'b1; dm_ready = 1'b1; rd_word = 32'h0;
      #3;
      check_eq("rst_dm_en",  32'(dm_en),    32'd0);
      check_eq("rst_dm_wen", 32'(dm_wen),   32'd0);
      check_eq("rst_over",   32'(MEM_over), 32'd0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      // ALU op completes in the same cycle
      MEM_valid = 1'b1;
      EXE_MEM_bus_r = mk(C_ALU, 32'h0, 32'h1234_5678, 5'd7, 32'hBFC0_0000);
      #1;
      check_eq("alu_over",  32'(MEM_over),  32'd1);
      check_eq("alu_en",    32'(dm_en),     32'd0);
      check_eq("alu_res",   o_res,          32'h1234_5678);
      check_eq("alu_wdest", 32'(MEM_wdest), 32'd7);
      check_eq("alu_pc",    MEM_pc,         32'hBFC0_0000);
      check_eq("alu_bpc",   o_pc,           32'hBFC0_0000);
      check_eq("alu_cp0r",  32'(o_cp0r),    32'hA5);
      check_eq("alu_flags", 32'(o_flags),   32'h2A);
      check_eq("alu_misc",  32'({o_rf_wen, o_wdest, o_sys, o_ovf, o_aerr}), 32'({1'b1, 5'd7, 2'b10, 1'b1, 1'b0}));
      check_eq("alu_lo",    o_lo,           32'h0000_1111);
      step();

      // lw 0x100
      rd_word = 32'hDEAD_BEEF;
      EXE_MEM_bus_r = mk(C_LW, 32'h0, 32'h100, 5'd8, 32'h4);
      #1;
      check_eq("lw_en",    32'(dm_en),    32'd1);
      check_eq("lw_addr",  dm_addr,       32'h100);
      check_eq("lw_wen",   32'(dm_wen),   32'd0);
      check_eq("lw_over0", 32'(MEM_over), 32'd0);
      step();
      check_eq("lw_c1_en",   32'(dm_en),    32'd0);
      check_eq("lw_c1_over", 32'(MEM_over), 32'd0);
      step();
      check_eq("lw_over", 32'(MEM_over), 32'd1);
      check_eq("lw_res",  o_res,         32'hDEAD_BEEF);
      check_eq("lw_aerr", 32'(o_aerr),   32'd0);
      step();

      // lb signed 0x103, issued back to back
      rd_word = 32'h8012_3456;
      EXE_MEM_bus_r = mk(C_LB, 32'h0, 32'h103, 5'd9, 32'h8);
      #1;
      check_eq("lb_b2b_en", 32'(dm_en), 32'd1);
      step(); step();
      check_eq("lb_over", 32'(MEM_over), 32'd1);
      check_eq("lb_res",  o_res,         32'hFFFF_FF80);
      step();

      // lbu 0x103
      EXE_MEM_bus_r = mk(C_LBU, 32'h0, 32'h103, 5'd9, 32'hC);
      #1; step(); step();
      check_eq("lbu_res", o_res, 32'h0000_0080);
      step();

      // lb signed 0x101
      rd_word = 32'h0000_F400;
      EXE_MEM_bus_r = mk(C_LB, 32'h0, 32'h101, 5'd9, 32'h10);
      #1; step(); step();
      check_eq("lb1_res", o_res, 32'hFFFF_FFF4);
      step();

      // sb 0x102
      EXE_MEM_bus_r = mk(C_SB, 32'h0000_00AB, 32'h102, 5'd0, 32'h14);
      #1;
      check_eq("sb_en",    32'(dm_en),    32'd1);
      check_eq("sb_wen",   32'(dm_wen),   32'h4);
      check_eq("sb_wdata", dm_wdata,      32'hABAB_ABAB);
      check_eq("sb_over0", 32'(MEM_over), 32'd0);
      wc = wr_cnt;
      step();
      check_eq("sb_over",   32'(MEM_over),  32'd1);
      check_eq("sb_en_off", 32'(dm_en),     32'd0);
      check_eq("sb_writes", 32'(wr_cnt - wc), 32'd1);
      check_eq("sb_res",    o_res,          32'h102);
      step();

      // sw 0x104
      EXE_MEM_bus_r = mk(C_SW, 32'hCAFE_F00D, 32'h104, 5'd0, 32'h18);
      #1;
      check_eq("sw_wen",   32'(dm_wen), 32'hF);
      check_eq("sw_wdata", dm_wdata,    32'hCAFE_F00D);
      step();
      check_eq("sw_over", 32'(MEM_over), 32'd1);
      step();

      // misaligned sw 0x101
      EXE_MEM_bus_r = mk(C_SW, 32'h1111_2222, 32'h101, 5'd0, 32'h1C);
      #1;
      check_eq("mis_en",   32'(dm_en),    32'd0);
      check_eq("mis_aerr", 32'(o_aerr),   32'd1);
      check_eq("mis_over", 32'(MEM_over), 32'd1);
      wc = wr_cnt;
      step();
      check_eq("mis_writes", 32'(wr_cnt - wc), 32'd0);

      // misaligned lw 0x102
      EXE_MEM_bus_r = mk(C_LW, 32'h0, 32'h102, 5'd3, 32'h20);
      #1;
      check_eq("mlw_en",   32'(dm_en),    32'd0);
      check_eq("mlw_aerr", 32'(o_aerr),   32'd1);
      check_eq("mlw_over", 32'(MEM_over), 32'd1);
      step();

      // lw 0x200 with ready low 3 cycles, then WB stalled 2 cycles
      wb_allow = 1'b0; dm_ready = 1'b0; rd_word = 32'h1122_3344;
      EXE_MEM_bus_r = mk(C_LW, 32'h0, 32'h200, 5'd4, 32'h24);
      #1;
      for (int i = 0; i < 3; i++) begin
         check_eq("st_en",   32'(dm_en),    32'd1);
         check_eq("st_addr", dm_addr,       32'h200);
         check_eq("st_over", 32'(MEM_over), 32'd0);
         step();
      end
      dm_ready = 1'b1;
      #1;
      check_eq("st_en_acc", 32'(dm_en), 32'd1);
      step(); step();
      check_eq("st_over_done", 32'(MEM_over), 32'd1);
      check_eq("st_res",       o_res,         32'h1122_3344);
      snap = MEM_WB_bus;
      for (int i = 0; i < 2; i++) begin
         step();
         check_eq("st_hold_over", 32'(MEM_over), 32'd1);
         check_eq("st_hold_en",   32'(dm_en),    32'd0);
         check_eq("st_hold_bus",  32'(MEM_WB_bus == snap), 32'd1);
      end
      wb_allow = 1'b1;
      step();

      // reset pulse while in RDATA
      rd_word = 32'h5566_7788;
      EXE_MEM_bus_r = mk(C_LW, 32'h0, 32'h300, 5'd5, 32'h28);
      #1; step();
      resetn = 1'b0;
      #1;
      check_eq("rr_over", 32'(MEM_over), 32'd0);
      check_eq("rr_en",   32'(dm_en),    32'd0);
      MEM_valid = 1'b0;
      step();
      resetn = 1'b1;
      MEM_valid = 1'b1;
      #1;
      check_eq("rr_idle_en", 32'(dm_en), 32'd1);
      step(); step();
      check_eq("rr_res", o_res, 32'h5566_7788);
      step();

      // flush of an unaccepted request in IDLE
      dm_ready = 1'b0;
      EXE_MEM_bus_r = mk(C_LW, 32'h0, 32'h400, 5'd6, 32'h2C);
      #1;
      check_eq("fl_en", 32'(dm_en), 32'd1);
      MEM_valid = 1'b0;
      #1;
      check_eq("fl_en_drop", 32'(dm_en),     32'd0);
      check_eq("fl_wdest",   32'(MEM_wdest), 32'd0);
      step();

      // flush while in RDATA
      MEM_valid = 1'b1; dm_ready = 1'b1; rd_word = 32'h0000_0099;
      #1; step();
      MEM_valid = 1'b0;
      #1; step();
      check_eq("flr_over", 32'(MEM_over), 32'd0);
      step();
      MEM_valid = 1'b1;
      EXE_MEM_bus_r = mk(C_LW, 32'h0, 32'h404, 5'd6, 32'h30);
      #1;
      check_eq("flr_idle_en", 32'(dm_en), 32'd1);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage of the five-stage pipeline; sits directly downstream of the execute stage.
- Consumes the registered 155-bit EXE->MEM bus and performs load/store against a data RAM with a request/ready handshake.
- Aligns and extends load data, detects misaligned word accesses, and produces the 120-bit MEM->WB bus.
- Multi-cycle for memory instructions; single-pass (combinational completion) for all others.

Parameters:
- EXE_MEM_W, 155, width of incoming bus.
- MEM_WB_W, 120, width of outgoing bus.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- MEM_valid  in  1  stage holds a valid instruction.
- EXE_MEM_bus_r  in  155  {mem_control[3:0], store_data, exe_result, lo_result, hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[7:0], syscall, eret, rf_wen, rf_wdest[4:0], overflow, pc}.
- mem_control  n/a  4  field of EXE_MEM_bus_r = {inst_load, inst_store, ls_word, lb_sign}.
- MEM_WB_go  in  1  instruction leaves stage at this edge (MEM_over & WB_allow_in).
- dm_ready  in  1  RAM accepts request this cycle.
- dm_rdata  in  32  read data, valid the cycle after load acceptance.
- dm_en  out  1  access request.
- dm_wen  out  4  byte write enables (0 for loads).
- dm_addr  out  32  byte address = exe_result.
- dm_wdata  out  32  store data.
- MEM_over  out  1  stage complete.
- MEM_WB_bus  out  120  {rf_wen, rf_wdest, mem_result, lo_result, hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, eret, overflow, addr_err, pc}.
- MEM_wdest  out  5  rf_wdest & {5{MEM_valid}}.
- MEM_pc  out  32  pc field.

Behaviour:
- Reset (resetn=0, async):
  - state=IDLE; load_data=0.
  - dm_en=0, dm_wen=0, MEM_over=0.
  - Reset mid-access abandons the access; any accepted store is not retracted.
- Address and data formatting:
  - mis = ls_word & (addr[1:0]!=0); addr_err = mis & (inst_load|inst_store).
  - Misaligned accesses issue no request and complete with MEM_over=1 in the same cycle. No write ever occurs for them.
  - Store word: dm_wen=4'hF, dm_wdata=store_data.
  - Store byte: dm_wen=4'b0001<<addr[1:0], dm_wdata={4{store_data[7:0]}}.
- States:
  - IDLE:
    - dm_en = MEM_valid & (inst_load|inst_store) & ~mis.
    - Non-memory or misaligned instruction: MEM_over = MEM_valid.
    - dm_en & dm_ready: load -> RDATA; store -> DONE.
    - dm_en & ~dm_ready: stay in IDLE; request held stable.
  - RDATA: load_data <= dm_rdata; -> DONE. MEM_over=0.
  - DONE:
    - MEM_over=1; dm_en=0.
    - MEM_WB_go -> IDLE.
    - MEM_valid=0 (flush) -> IDLE.
- Latency from acceptance edge:
  - Store: MEM_over the following cycle.
  - Load: MEM_over two cycles after acceptance.
  - With dm_ready tied high, a load completes 2 cycles after entering the stage.
- mem_result:
  - Load word: load_data.
  - Load byte: byte selected by addr[1:0] of load_data; sign-extended if lb_sign, else zero-extended.
  - Otherwise: exe_result.
- Flush:
  - MEM_valid falling in IDLE withdraws an unaccepted request (dm_en=0 that cycle).
  - MEM_valid falling in RDATA still captures rdata, then returns to IDLE via DONE without asserting MEM_over.
- Back-to-back:
  - DONE & MEM_WB_go returns to IDLE at the edge.
  - A new memory instruction issues dm_en the next cycle; no dead cycle is permitted beyond this.
- Outputs are stable while stalled in DONE (bus fields come from the held input register plus load_data).

Decomposition:
- Shared package holds:
  - Bus widths.
  - mem_control bit positions.
  - State encoding IDLE/RDATA/DONE.
  - MEM_WB bus field offsets, shared with the writeback stage.
- One sub-module is natural: load_align (combinational byte select/extend).

Test Plan:
- ALU op, exe_result=0x12345678, MEM_valid=1 -> MEM_over=1 same cycle, dm_en=0, mem_result=0x12345678.
- lw addr=0x100, dm_ready=1, RAM[0x100]=0xDEADBEEF -> dm_en one cycle, MEM_over at cycle 2, mem_result=0xDEADBEEF.
- lb signed addr=0x103, word=0x80xxxxxx -> mem_result=0xFFFFFF80; lbu gives 0x00000080.
- sb addr=0x102, store_data=0x000000AB -> dm_wen=4'b0100, dm_wdata=0xABABABAB, MEM_over next cycle.
- sw addr=0x101 -> no dm_en, addr_err=1, MEM_over same cycle.
- lw with dm_ready low 3 cycles, then MEM_WB_go held low 2 cycles in DONE:
  - dm_en/dm_addr stable throughout the wait.
  - Outputs stable while stalled in DONE.
  - resetn pulse in RDATA -> state IDLE, MEM_over=0 immediately.
